// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32IM pipeline control logic: run-state
// encoding and default counter width.
package riscv_pkg;

   localparam int CNT_W_DEFAULT = 32;
   localparam int DRAIN_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clear) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + ONE;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Run sequencer and hazard arbiter for the 5-stage pipeline: drives every
// stage stall/flush, the start/done handshake and the performance counters.
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   input  logic             md_alu_stall,
   input  logic             load_use_hazard,
   input  logic             mispredict,
   input  logic             ex_mem_ecall,
   output logic             riscv_start,
   output logic             riscv_done,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_stall,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

   state_t               state_reg;
   logic                 start_reg;
   logic                 done_reg;
   logic                 mis_pend_reg;
   logic [DRAIN_W-1:0]   drain_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         start_reg     <= 1'b0;
         done_reg      <= 1'b0;
         mis_pend_reg  <= 1'b0;
         drain_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg <= ST_RUN;
                  start_reg <= 1'b1;
               end
            end
            ST_RUN: begin
               // A redirect seen under a data-cache stall is replayed once the stall lifts.
               if (dcache_stall) begin
                  if (mispredict) begin
                     mis_pend_reg <= 1'b1;
                  end
               end else begin
                  mis_pend_reg <= 1'b0;
                  if (ex_mem_ecall) begin
                     state_reg     <= ST_DRAIN;
                     drain_cnt_reg <= DRAIN_INIT;
                  end
               end
            end
            ST_DRAIN: begin
               if (!dcache_stall) begin
                  if (drain_cnt_reg <= DRAIN_ONE) begin
                     state_reg     <= ST_DONE;
                     start_reg     <= 1'b0;
                     done_reg      <= 1'b1;
                     drain_cnt_reg <= '0;
                  end else begin
                     drain_cnt_reg <= drain_cnt_reg - DRAIN_ONE;
                  end
               end
            end
            ST_DONE: begin
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign riscv_start = start_reg;
   assign riscv_done  = done_reg;

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_stall = 1'b0;
      mem_wb_flush = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (dcache_stall) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_stall  = 1'b1;
               mem_wb_stall = 1'b1;
            end else if (ex_mem_ecall) begin
               pc_stall     = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
            end else if (mispredict || mis_pend_reg) begin
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
            end else if (md_alu_stall) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_stall  = 1'b1;
               mem_wb_flush = 1'b1;
            end else if (load_use_hazard) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_flush  = 1'b1;
            end else if (icache_stall) begin
               pc_stall     = 1'b1;
               if_id_flush  = 1'b1;
            end
         end
         ST_DRAIN: begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end
         default: begin
         end
      endcase
   end

   logic cycle_inc;
   logic stall_inc;

   assign cycle_inc = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign stall_inc = (state_reg == ST_RUN) && pc_stall;

   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (cycle_inc),
      .count (cycle_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: priority table, hand-written multi-cycle sequences
// and random traffic checked against a cycle-level reference model.
module tb_pipeline_ctrl;

   localparam int TB_W  = 5;
   localparam int DRAIN = 2;
   localparam int SAT   = (1 << TB_W) - 1;

   typedef struct packed {
      logic icache;
      logic dcache;
      logic md;
      logic lu;
      logic mis;
      logic ecall;
      logic start;
   } hz_t;

   typedef struct {
      hz_t        in;
      logic [7:0] exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start, icache_stall, dcache_stall, md_alu_stall;
   logic            load_use_hazard, mispredict, ex_mem_ecall;
   logic            riscv_start, riscv_done;
   logic            pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic            ex_mem_flush, mem_wb_stall, mem_wb_flush;
   logic [TB_W-1:0] cycle_count, stall_count;

   int tests = 0;
   int fails = 0;

   // Reference model state: 0 idle, 1 run, 2 drain, 3 done
   int   m_state;
   int   m_drain;
   bit   m_pend;
   int   m_cyc;
   int   m_stl;
   bit   m_start;
   bit   m_done;
   logic [7:0] last_comb;

   always #5 clk = ~clk;

   pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(TB_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .icache_stall    (icache_stall),
      .dcache_stall    (dcache_stall),
      .md_alu_stall    (md_alu_stall),
      .load_use_hazard (load_use_hazard),
      .mispredict      (mispredict),
      .ex_mem_ecall    (ex_mem_ecall),
      .riscv_start     (riscv_start),
      .riscv_done      (riscv_done),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .if_id_flush     (if_id_flush),
      .id_ex_stall     (id_ex_stall),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .mem_wb_stall    (mem_wb_stall),
      .mem_wb_flush    (mem_wb_flush),
      .cycle_count     (cycle_count),
      .stall_count     (stall_count)
   );

   function automatic hz_t mk(input bit ic, input bit dc, input bit md, input bit lu,
                              input bit mis, input bit ec, input bit st);
      hz_t h;
      h.icache = ic; h.dcache = dc; h.md = md; h.lu = lu;
      h.mis = mis; h.ecall = ec; h.start = st;
      return h;
   endfunction

   // Expected {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, mem_wb_stall, mem_wb_flush}
   function automatic logic [7:0] model_comb(input hz_t h);
      string winner;
      if (m_state == 2) return 8'b1100_1100;
      if (m_state != 1) return 8'b0;
      if (h.dcache)               winner = "dcache";
      else if (h.ecall)           winner = "ecall";
      else if (h.mis || m_pend)   winner = "redirect";
      else if (h.md)              winner = "muldiv";
      else if (h.lu)              winner = "loaduse";
      else if (h.icache)          winner = "icache";
      else                        winner = "none";
      case (winner)
         "dcache":   return 8'b1101_0010;
         "ecall":    return 8'b1010_1100;
         "redirect": return 8'b0010_1100;
         "muldiv":   return 8'b1101_0001;
         "loaduse":  return 8'b1100_1000;
         "icache":   return 8'b1010_0000;
         default:    return 8'b0;
      endcase
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic model_edge(input hz_t h, input bit pcs);
      case (m_state)
         0: if (h.start) begin m_state = 1; m_start = 1; end
         1: begin
            m_cyc = sat_inc(m_cyc);
            if (pcs) m_stl = sat_inc(m_stl);
            if (h.dcache) begin
               if (h.mis) m_pend = 1;
            end else begin
               m_pend = 0;
               if (h.ecall) begin m_state = 2; m_drain = DRAIN; end
            end
         end
         2: begin
            m_cyc = sat_inc(m_cyc);
            if (!h.dcache) begin
               m_drain = m_drain - 1;
               if (m_drain == 0) begin m_state = 3; m_start = 0; m_done = 1; end
            end
         end
         default: ;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input hz_t h);
      icache_stall    = h.icache;
      dcache_stall    = h.dcache;
      md_alu_stall    = h.md;
      load_use_hazard = h.lu;
      mispredict      = h.mis;
      ex_mem_ecall    = h.ecall;
      start           = h.start;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".riscv_start"}, 32'(riscv_start), 32'(m_start));
      check({tag, ".riscv_done"},  32'(riscv_done),  32'(m_done));
      check({tag, ".cycle_count"}, 32'(cycle_count), 32'(m_cyc));
      check({tag, ".stall_count"}, 32'(stall_count), 32'(m_stl));
   endtask

   // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
   task automatic step(input hz_t h);
      logic [7:0] exp;
      drive(h);
      #3;
      exp = model_comb(h);
      last_comb = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_flush, mem_wb_stall, mem_wb_flush};
      check("comb", 32'(last_comb), 32'(exp));
      @(posedge clk);
      model_edge(h, exp[7]);
      #1;
      check_regs("step");
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive('0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_state = 0; m_drain = 0; m_pend = 0;
      m_cyc = 0; m_stl = 0; m_start = 0; m_done = 0;
      check_regs("reset");
   endtask

   task automatic reset_and_run();
      do_reset();
      step(mk(0,0,0,0,0,0,1));
   endtask

   vec_t tbl[12];
   hz_t  none_h;
   int   frozen;

   initial begin
      none_h = '0;
      do_reset();

      // Start handshake and first counter values
      step(none_h);
      step(none_h);
      check("idle.riscv_start", 32'(riscv_start), 32'd0);
      step(mk(0,0,0,0,0,0,1));
      check("start_next_cycle", 32'(riscv_start), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(none_h);
         check("run.no_hazard", 32'(last_comb), 32'd0);
      end
      check("cycle_count_5", 32'(cycle_count), 32'd5);
      $display("[TB] seq start: riscv_start=%0b cycle_count=%0d", riscv_start, cycle_count);

      // Priority table, applied back to back in RUN
      tbl[0]  = '{mk(0,0,0,0,0,0,0), 8'b0000_0000};
      tbl[1]  = '{mk(1,0,0,0,0,0,0), 8'b1010_0000};
      tbl[2]  = '{mk(0,0,0,1,0,0,0), 8'b1100_1000};
      tbl[3]  = '{mk(1,0,0,1,0,0,0), 8'b1100_1000};
      tbl[4]  = '{mk(0,0,1,0,0,0,0), 8'b1101_0001};
      tbl[5]  = '{mk(1,0,1,1,0,0,0), 8'b1101_0001};
      tbl[6]  = '{mk(0,0,0,0,1,0,0), 8'b0010_1100};
      tbl[7]  = '{mk(1,0,1,1,1,0,0), 8'b0010_1100};
      tbl[8]  = '{mk(0,1,0,0,0,0,0), 8'b1101_0010};
      tbl[9]  = '{mk(0,1,1,0,1,0,0), 8'b1101_0010};
      tbl[10] = '{mk(1,0,0,0,0,0,0), 8'b0010_1100};
      tbl[11] = '{mk(1,0,0,0,0,0,0), 8'b1010_0000};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].in);
         check($sformatf("table[%0d]", i), 32'(last_comb), 32'(tbl[i].exp));
         $display("[TB] table %0d: in=%07b out=%08b", i, tbl[i].in, last_comb);
      end

      // Data-cache stall with a mispredict buried in it
      reset_and_run();
      for (int i = 0; i < 4; i++) begin
         step(mk(0,1,0,0,(i == 1),0,0));
         check("dcache_hold", 32'(last_comb), 32'b1101_0010);
      end
      step(none_h);
      check("pending_redirect", 32'(last_comb), 32'b0010_1100);
      step(none_h);
      check("redirect_once", 32'(last_comb), 32'd0);
      $display("[TB] seq dcache+mispredict: stall_count=%0d", stall_count);

      // Mul/div over load-use
      reset_and_run();
      for (int i = 0; i < 3; i++) begin
         step(mk(0,0,1,1,0,0,0));
         check("md_over_lu", 32'(last_comb), 32'b1101_0001);
      end
      check("stall_count_3", 32'(stall_count), 32'd3);
      step(mk(0,0,0,1,1,0,0));
      check("mis_over_lu", 32'(last_comb), 32'b0010_1100);
      $display("[TB] seq muldiv/loaduse: stall_count=%0d", stall_count);

      // ecall drain with one data-cache stall cycle
      reset_and_run();
      step(none_h);
      step(mk(0,0,0,0,0,1,0));
      check("ecall_cycle", 32'(last_comb), 32'b1010_1100);
      step(mk(0,1,0,0,0,0,0));
      check("drain1.comb", 32'(last_comb), 32'b1100_1100);
      check("drain1.done", 32'(riscv_done), 32'd0);
      step(none_h);
      check("drain2.done", 32'(riscv_done), 32'd0);
      step(none_h);
      check("drain3.done", 32'(riscv_done), 32'd1);
      check("drain3.start", 32'(riscv_start), 32'd0);
      frozen = int'(cycle_count);
      check("cycle_at_done", 32'(cycle_count), 32'd5);
      step(mk(0,0,0,0,0,0,1));
      step(none_h);
      check("done.frozen", 32'(cycle_count), 32'(frozen));
      check("done.ignore_start", 32'(riscv_start), 32'd0);
      check("done.comb_zero", 32'(last_comb), 32'd0);
      $display("[TB] seq drain: done=%0b cycle_count=%0d", riscv_done, cycle_count);

      // Reset while draining
      reset_and_run();
      step(mk(0,0,0,0,0,1,0));
      step(none_h);
      do_reset();
      check("rst_drain.done", 32'(riscv_done), 32'd0);
      check("rst_drain.cycles", 32'(cycle_count), 32'd0);
      step(none_h);
      check("rst_drain.idle", 32'(last_comb), 32'd0);
      $display("[TB] seq reset-in-drain: state idle, counters %0d/%0d", cycle_count, stall_count);

      // Random traffic; long runs also push the narrow counters into saturation
      for (int r = 0; r < 8; r++) begin
         reset_and_run();
         for (int c = 0; c < 120; c++) begin
            hz_t h;
            h.icache = ($urandom_range(3) == 0);
            h.dcache = ($urandom_range(3) == 0);
            h.md     = ($urandom_range(4) == 0);
            h.lu     = ($urandom_range(4) == 0);
            h.mis    = ($urandom_range(5) == 0);
            h.ecall  = ($urandom_range(70) == 0);
            h.start  = ($urandom_range(9) == 0);
            step(h);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central run/hazard controller for the 5-stage RV32IM pipeline.
- Sequences the core through start, run, drain and done, and generates `riscv_start`/`riscv_done`.
- Generates every per-stage stall/flush signal, consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers and by the PC.
- Arbitrates simultaneous hazards by fixed priority and keeps performance counters.

Parameters:
- DRAIN_CYCLES, 2, cycles after ecall leaves MEM before `riscv_done` asserts (lets the ecall and older stores retire through WB); legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset
- start  input  1  one-cycle run request from host
- icache_stall  input  1  fetch miss in progress
- dcache_stall  input  1  data cache miss in progress
- md_alu_stall  input  1  multi-cycle mul/div busy in EX
- load_use_hazard  input  1  ID instr needs EX-stage load result
- mispredict  input  1  branch/jal resolved in MEM disagrees with prediction
- ex_mem_ecall  input  1  ecall currently in MEM
- riscv_start  output  1  core running (registered)
- riscv_done  output  1  program finished (registered, sticky)
- pc_stall  output  1  hold PC
- if_id_stall, if_id_flush  output  1 each
- id_ex_stall, id_ex_flush  output  1 each
- ex_mem_flush  output  1  bubble into EX/MEM
- mem_wb_stall, mem_wb_flush  output  1 each
- cycle_count  output  CNT_W  cycles spent in RUN+DRAIN
- stall_count  output  CNT_W  RUN cycles with `pc_stall`=1

Behaviour:
- Clock `clk`; reset is synchronous and active-high on `reset`.
- Reset: state=IDLE, `riscv_start`=0, `riscv_done`=0, counters=0, drain counter=0, `mis_pend`=0. All stall/flush outputs are 0 in IDLE and DONE. Reset in any state returns to IDLE on the next edge.

State machine, states IDLE/RUN/DRAIN/DONE:
- IDLE→RUN on `start`. `riscv_start`=1 from the next cycle.
- RUN→DRAIN when `ex_mem_ecall`=1 and `dcache_stall`=0. That cycle flushes IF/ID, ID/EX and EX/MEM and stalls the PC. The drain counter loads DRAIN_CYCLES.
- DRAIN: PC and IF/ID stalled; ID/EX and EX/MEM flushed every cycle.
  - Counter decrements only when `dcache_stall`=0.
  - At 0, go to DONE.
- DONE: `riscv_start`=0, `riscv_done`=1, terminal until reset. `start` is ignored in RUN, DRAIN and DONE.

Hazard priority in RUN (combinational outputs, highest first):
1. `dcache_stall`: `pc_stall`, `if_id_stall`, `id_ex_stall` and `mem_wb_stall` =1. EX/MEM holds via its own `dcache_stall` input. No flush is issued. If `mispredict`=1 this cycle, set `mis_pend`.
2. `mispredict` or `mis_pend`: `if_id_flush`, `id_ex_flush` and `ex_mem_flush` =1. PC is not stalled (it loads the redirect). Clear `mis_pend`.
3. `md_alu_stall`: `pc_stall`, `if_id_stall` and `id_ex_stall` =1. `mem_wb_flush`=1 (bubble into WB).
4. `load_use_hazard`: `pc_stall` and `if_id_stall` =1, `id_ex_flush`=1.
5. `icache_stall`: `pc_stall`=1, `if_id_flush`=1.
- Stall and flush for the same register are never both 1; flush wins only where the list says so.

Counters:
- `cycle_count` increments every RUN or DRAIN cycle and saturates at all-ones.
- `stall_count` increments in RUN when `pc_stall`=1 and saturates.
- Both hold in DONE and clear only on reset.

Decomposition:
- Shared package `riscv_pkg`: state encoding localparams ST_IDLE=0, ST_RUN=1, ST_DRAIN=2, ST_DONE=3, and the CNT_W default.
- One sub-module, `sat_counter` (width param, inc, clear, saturating), instantiated twice for the counters.
- The hazard priority encoder stays inline.

Test Plan:
- Reset, then `start` at cycle 3 → `riscv_start`=1 at cycle 4; `cycle_count`=5 after 5 RUN cycles; all stall/flush 0 with no hazards.
- `dcache_stall`=1 for 4 cycles with `mispredict` pulsed in the 2nd → 4 cycles of `pc_stall`/`if_id_stall`/`id_ex_stall`/`mem_wb_stall`, no flush; on the cycle `dcache_stall` drops, `if_id_flush`/`id_ex_flush`/`ex_mem_flush`=1 exactly once.
- `md_alu_stall` and `load_use_hazard` both =1 for 3 cycles → `id_ex_stall`=1, `id_ex_flush`=0, `mem_wb_flush`=1 for 3 cycles; `stall_count`=3.
- `mispredict` and `load_use_hazard` simultaneous → `id_ex_flush`=1, `pc_stall`=0, `ex_mem_flush`=1.
- `ex_mem_ecall`=1 with DRAIN_CYCLES=2 and `dcache_stall`=1 for 1 drain cycle → DONE after 3 drain cycles; `riscv_done`=1 and `riscv_start`=0; a later `start` is ignored; `cycle_count` frozen.
- Reset asserted in DRAIN → next cycle IDLE, counters 0, `riscv_done`=0.
